// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared constants and elaboration-time helpers for the
//                parametrised sequence detector. The KMP transition rule and
//                the pattern border length are computed here so the
//                detector can build its transition table as constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int MIN_PAT_W      = 2;
    localparam int MAX_PAT_W      = 16;
    // Widest prefix-length register any legal pattern can need.
    localparam int MAX_PREFIX_W   = $clog2(MAX_PAT_W);

    typedef logic [MAX_PAT_W-1:0] pattern_t;

    // Behaviour of the tracker right after a complete match.
    typedef enum logic {
        MODE_RESTART = 1'b0,
        MODE_OVERLAP = 1'b1
    } overlap_mode_e;

    // Pattern bit i in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input pattern_t pattern, input int pat_w, input int i);
        return pattern[pat_w-1-i];
    endfunction

    // Length of the longest proper prefix of the pattern that is also a suffix.
    function automatic int border_len(input pattern_t pattern, input int pat_w);
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j < pat_w; j++) begin
            ok = 1'b1;
            for (int m = 0; m < j; m++) begin
                if (pat_bit(pattern, pat_w, pat_w-j+m) != pat_bit(pattern, pat_w, m))
                    ok = 1'b0;
            end
            if (ok)
                best = j;
        end
        return best;
    endfunction

    // KMP transition: state k (k pattern bits matched) receiving bit b.
    function automatic int next_prefix(input pattern_t      pattern,
                                       input int            pat_w,
                                       input int            k,
                                       input logic          b,
                                       input overlap_mode_e overlap);
        logic [MAX_PAT_W:0] s;
        int                 n;
        int                 j_max;
        logic               ok;
        // A completed pattern resets to the border or to empty.
        if ((k == pat_w-1) && (b == pat_bit(pattern, pat_w, k)))
            return (overlap == MODE_OVERLAP) ? border_len(pattern, pat_w) : 0;
        // s = first k pattern bits followed by b
        s = '0;
        for (int i = 0; i <= MAX_PAT_W; i++) begin
            if (i < k)
                s[i] = pat_bit(pattern, pat_w, i);
            else if (i == k)
                s[i] = b;
        end
        n     = k + 1;
        j_max = (n < pat_w) ? n : pat_w - 1;
        for (int j = j_max; j >= 1; j--) begin
            ok = 1'b1;
            for (int m = 0; m < j; m++) begin
                if (s[n-j+m] != pat_bit(pattern, pat_w, m))
                    ok = 1'b0;
            end
            if (ok)
                return j;
        end
        return 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that sticks at its maximum value.
//                A clear request wins over a simultaneous increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Clear first, then a saturating increment.
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (inc && (r_count != {W{1'b1}}))
            r_count <= r_count + W'(1);
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Parametrised serial pattern detector (KMP prefix tracker)
//                with input-valid qualifier, overlap selection and a
//                saturating match counter. The transition table is a set of
//                elaboration-time constants.
//                Optional macro SEQ_DET_MATCH_REG_EN: when defined, match is
//                registered and asserts one cycle after the completing bit;
//                otherwise match is the combinational Mealy output.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_bit,
    input  logic                     cnt_clr,
    output logic                     match,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [$clog2(PAT_W)-1:0] prefix_len
);

    localparam int            c_pw    = $clog2(PAT_W);
    localparam int            c_tbl_n = 2 ** (c_pw + 1);
    localparam overlap_mode_e c_mode  = (OVERLAP != 0) ? MODE_OVERLAP : MODE_RESTART;

    if ((PAT_W < MIN_PAT_W) || (PAT_W > MAX_PAT_W)) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W=%0d outside legal range 2..16", PAT_W);
    end

    // Transition table indexed by {state, bit}; unreachable states map to 0.
    logic [c_pw-1:0] w_next_tbl [c_tbl_n];

    for (genvar g = 0; g < c_tbl_n; g++) begin : g_tbl
        localparam int c_k = g / 2;
        localparam int c_b = g % 2;
        if (c_k < PAT_W) begin : g_live
            assign w_next_tbl[g] = c_pw'(next_prefix(pattern_t'(PATTERN), PAT_W, c_k,
                                                     (c_b != 0), c_mode));
        end else begin : g_unused
            assign w_next_tbl[g] = '0;
        end
    end

    logic [c_pw-1:0] r_state;
    logic [c_pw-1:0] w_state_nxt;
    logic            w_match;

    // Prefix-length state register; invalid cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= '0;
        else
            r_state <= w_state_nxt;
    end

    // Next prefix via the constant table; match when the last pattern bit lands.
    always_comb begin
        w_state_nxt = r_state;
        w_match     = 1'b0;
        if (in_valid) begin
            w_state_nxt = w_next_tbl[{r_state, in_bit}];
            w_match     = (r_state == c_pw'(PAT_W-1)) && (in_bit == PATTERN[0]);
        end
    end

`ifdef SEQ_DET_MATCH_REG_EN
    logic r_match;

    // Registered match: glitch-free, one cycle behind the completing bit.
    always_ff @(posedge clk) begin
        if (rst)
            r_match <= 1'b0;
        else
            r_match <= w_match;
    end

    assign match = r_match;
`else
    assign match = w_match;
`endif

    sat_counter #(
        .W     (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_match),
        .count (match_cnt)
    );

    assign prefix_len = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Self-checking bench for seq_detector_param. Four instances
//                (101 overlap, 101 restart, 1101 overlap, 101 with a 2-bit
//                counter) share one stimulus stream; each is compared with a
//                history-based reference model. Honours SEQ_DET_MATCH_REG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_bit;
    logic cnt_clr;

    logic       dut_m   [4];
    logic [1:0] dut_pl  [4];
    logic [7:0] dut_cnt [3];
    logic [1:0] cnt_d;

    int total = 0;
    int bad   = 0;

    // Instance configuration for the reference model
    int cfg_pw  [4] = '{3, 3, 4, 3};
    int cfg_pat [4] = '{5, 5, 13, 5};
    int cfg_ov  [4] = '{1, 0, 1, 1};
    int cfg_max [4] = '{255, 255, 255, 3};

    // Model state: recent valid bits (newest in bit 0) and how many are live
    longint unsigned hist [4];
    int              hlen [4];
    int              mcnt [4];
    bit              mreg [4];

    always #5 clk = ~clk;

    seq_detector_param u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
        .match(dut_m[0]), .match_cnt(dut_cnt[0]), .prefix_len(dut_pl[0]));

    seq_detector_param #(.OVERLAP(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
        .match(dut_m[1]), .match_cnt(dut_cnt[1]), .prefix_len(dut_pl[1]));

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
        .match(dut_m[2]), .match_cnt(dut_cnt[2]), .prefix_len(dut_pl[2]));

    seq_detector_param #(.CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
        .match(dut_m[3]), .match_cnt(cnt_d), .prefix_len(dut_pl[3]));

    function automatic longint unsigned mask(input int j);
        return (64'd1 << j) - 64'd1;
    endfunction

    // Does this input complete the pattern, given the history since the last restart?
    function automatic bit m_match(input int i, input bit v, input bit b);
        longint unsigned h;
        if (!v)
            return 1'b0;
        h = (hist[i] << 1) | longint'(b);
        return ((hlen[i] + 1) >= cfg_pw[i]) &&
               ((h & mask(cfg_pw[i])) == longint'(cfg_pat[i]));
    endfunction

    // Longest suffix of the history (shorter than the pattern) equal to a pattern prefix
    function automatic int m_prefix(input int i);
        for (int j = cfg_pw[i] - 1; j >= 1; j--) begin
            if ((hlen[i] >= j) &&
                ((hist[i] & mask(j)) == (longint'(cfg_pat[i]) >> (cfg_pw[i] - j))))
                return j;
        end
        return 0;
    endfunction

    function automatic logic [31:0] get_cnt(input int i);
        return (i == 3) ? {30'd0, cnt_d} : {24'd0, dut_cnt[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive on negedge, check mid-cycle, advance model at posedge.
    task automatic step(input bit v, input bit b, input bit clr, input bit r);
        bit m [4];
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        cnt_clr  = clr;
        rst      = r;
        #1;
        for (int i = 0; i < 4; i++) begin
            m[i] = m_match(i, v, b);
`ifdef SEQ_DET_MATCH_REG_EN
            chk($sformatf("match[%0d]", i), {31'd0, dut_m[i]}, {31'd0, mreg[i]});
`else
            chk($sformatf("match[%0d]", i), {31'd0, dut_m[i]}, {31'd0, m[i]});
`endif
            chk($sformatf("prefix_len[%0d]", i), {30'd0, dut_pl[i]}, m_prefix(i));
            chk($sformatf("match_cnt[%0d]", i), get_cnt(i), mcnt[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                hist[i] = 0; hlen[i] = 0; mcnt[i] = 0; mreg[i] = 1'b0;
            end else begin
                mreg[i] = m[i];
                if (v) begin
                    hist[i] = (hist[i] << 1) | longint'(b);
                    if (hlen[i] < 32) hlen[i]++;
                    if (m[i] && (cfg_ov[i] == 0)) begin
                        hist[i] = 0; hlen[i] = 0;
                    end
                end
                if (clr)                               mcnt[i] = 0;
                else if (m[i] && mcnt[i] < cfg_max[i]) mcnt[i]++;
            end
        end
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        logic [15:0] bv;
        bv = bits;
        for (int k = n - 1; k >= 0; k--)
            step(1'b1, bv[k], 1'b0, 1'b0);
    endtask

    initial begin
        bit rv, vv;
        for (int i = 0; i < 4; i++) begin
            hist[i] = 0; hlen[i] = 0; mcnt[i] = 0; mreg[i] = 1'b0;
        end
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 1);

        // 1,0,1,0,1: overlap sees two matches, restart mode one
        send(16'b10101, 5);
        #2;
        chk("A_cnt_10101", get_cnt(0), 2);
        chk("A_prefix_10101", {30'd0, dut_pl[0]}, 1);
        chk("B_cnt_10101", get_cnt(1), 1);

        // 1101 streams on instance C
        step(0, 0, 0, 1);
        send(16'b1101101, 7);
        #2;
        chk("C_cnt_1101101", get_cnt(2), 2);
        step(0, 0, 0, 1);
        send(16'b11101, 5);
        #2;
        chk("C_cnt_11101", get_cnt(2), 1);

        // Invalid gap with in_bit=1 must not break or fake the sequence
        step(0, 0, 0, 1);
        send(16'b10, 2);
        repeat (3) step(0, 1, 0, 0);
        send(16'b1, 1);
        #2;
        chk("A_cnt_gap", get_cnt(0), 1);

        // Saturation of the 2-bit counter, then clear racing a match
        step(0, 0, 0, 1);
        send(16'b1, 1);
        repeat (5) send(16'b01, 2);
        #2;
        chk("D_cnt_sat", get_cnt(3), 3);
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        #2;
        chk("D_cnt_clr_vs_match", get_cnt(3), 0);
        chk("A_cnt_clr_vs_match", get_cnt(0), 0);

        // Reset mid-sequence discards the partial prefix
        send(16'b10, 2);
        step(0, 0, 0, 1);
        send(16'b1, 1);
        #2;
        chk("A_prefix_after_rst", {30'd0, dut_pl[0]}, 1);
        chk("A_cnt_after_rst", get_cnt(0), 0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 49) == 0);
            vv = ($urandom_range(0, 3) != 0) && !rv;
            step(vv, 1'($urandom), ($urandom_range(0, 19) == 0), rv);
        end
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
